// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Holds quotient and remainder so a paired DIV/REM can read the other result.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic             Signed,
    input  logic             RemSel,
    input  logic             Flush,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Result,
    output logic             Done,
    output logic             Busy,
    output logic             StallReq
);

    localparam int unsigned      CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } divState_e;

    divState_e        state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] qReg;
    logic [WIDTH-1:0] rReg;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] partial;
    logic             quotNeg;
    logic             remNeg;

    logic             accept;
    logic             negA;
    logic             negB;
    logic             divByZero;
    logic             overflow;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [WIDTH:0]   pShift;
    logic [WIDTH:0]   pSub;
    logic             geDiv;
    logic [WIDTH-1:0] pNext;
    logic [WIDTH-1:0] dNext;
    logic [WIDTH-1:0] qFinal;
    logic [WIDTH-1:0] rFinal;

    // Operand prep and one restoring step; the borrow of pSub doubles as the compare.
    always_comb begin
        accept    = (state != CALC);
        negA      = Signed & A[WIDTH-1];
        negB      = Signed & B[WIDTH-1];
        absA      = negA ? (~A + WIDTH'(1)) : A;
        absB      = negB ? (~B + WIDTH'(1)) : B;
        divByZero = (B == '0);
        overflow  = Signed & (A == MIN_INT) & (B == '1);
        pShift    = {partial, dividend[WIDTH-1]};
        pSub      = pShift - {1'b0, divisor};
        geDiv     = ~pSub[WIDTH];
        pNext     = geDiv ? pSub[WIDTH-1:0] : pShift[WIDTH-1:0];
        dNext     = {dividend[WIDTH-2:0], geDiv};
        qFinal    = quotNeg ? (~dNext + WIDTH'(1)) : dNext;
        rFinal    = remNeg ? (~pNext + WIDTH'(1)) : pNext;
    end

    assign Result   = RemSel ? rReg : qReg;
    assign Busy     = (state == CALC);
    assign StallReq = Busy | (Start & accept & ~(divByZero | overflow));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            cnt      <= '0;
            qReg     <= '0;
            rReg     <= '0;
            dividend <= '0;
            divisor  <= '0;
            partial  <= '0;
            quotNeg  <= 1'b0;
            remNeg   <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (Flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (!Start) begin
                            state <= IDLE;
                        end else if (divByZero) begin
                            qReg  <= '1;
                            rReg  <= A;
                            Done  <= 1'b1;
                            state <= DONE;
                        end else if (overflow) begin
                            qReg  <= A;
                            rReg  <= '0;
                            Done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            dividend <= absA;
                            divisor  <= absB;
                            partial  <= '0;
                            quotNeg  <= negA ^ negB;
                            remNeg   <= negA;
                            cnt      <= '0;
                            state    <= CALC;
                        end
                    end
                    CALC: begin
                        partial  <= pNext;
                        dividend <= dNext;
                        cnt      <= cnt + CW'(1);
                        if (cnt == LAST_CNT) begin
                            qReg  <= qFinal;
                            rReg  <= rFinal;
                            Done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
